// File: rtl/stl_txn_scheduler.sv
// Flow controller between the STL UART client packet streams and the UART<->TileLink bridges.
// Tracks in-flight source IDs, caps outstanding requests and injects error responses on timeout.
module stl_txn_scheduler #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned SRC_LSB         = 16,
    parameter int unsigned CHAN_LSB        = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         req_in_valid,
    output logic         req_in_ready,
    input  logic [127:0] req_in_data,
    output logic         req_out_valid,
    input  logic         req_out_ready,
    output logic [127:0] req_out_data,
    input  logic         rsp_in_valid,
    output logic         rsp_in_ready,
    input  logic [127:0] rsp_in_data,
    output logic         rsp_out_valid,
    input  logic         rsp_out_ready,
    output logic [127:0] rsp_out_data,
    output logic [3:0]   outstanding_count,
    output logic         timeout_pulse,
    output logic [7:0]   timeout_count,
    output logic [7:0]   unexpected_count
);

    localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {StFwd, StInj} rsp_state_e;

    logic [MAX_OUTSTANDING-1:0] valid_q, valid_d;
    logic [MAX_OUTSTANDING-1:0] expired_q, expired_d;
    logic [7:0]                 src_q [MAX_OUTSTANDING];
    logic [7:0]                 src_d [MAX_OUTSTANDING];
    logic [AGE_W-1:0]           age_q [MAX_OUTSTANDING];
    logic [AGE_W-1:0]           age_d [MAX_OUTSTANDING];

    rsp_state_e                 state_q, state_d;
    logic [MAX_OUTSTANDING-1:0] lock_oh_q, lock_oh_d;
    logic [7:0]                 lock_src_q, lock_src_d;

    logic [3:0] count_q, count_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0] unexp_cnt_q, unexp_cnt_d;
    logic       pulse_q, pulse_d;
    // Holds every handshake off while reset is asserted and for the first edge after release.
    logic       run_q;

    logic [7:0]                 req_src, rsp_src;
    logic                       dup, admit, req_hs, rsp_hs, inj_done;
    logic [MAX_OUTSTANDING-1:0] alloc_oh, match_oh, exp_oh, free_oh;
    logic [7:0]                 exp_src;
    logic [127:0]               synth_pkt;

    assign req_src = req_in_data[SRC_LSB +: 8];
    assign rsp_src = rsp_in_data[SRC_LSB +: 8];

    // Table lookups: duplicate source, lowest free slot, response match, lowest expired slot.
    always_comb begin
        dup      = 1'b0;
        alloc_oh = '0;
        match_oh = '0;
        exp_oh   = '0;
        exp_src  = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (valid_q[i] && src_q[i] == req_src) dup = 1'b1;
            if (valid_q[i] && src_q[i] == rsp_src) match_oh[i] = 1'b1;
        end
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_oh = '0;
            if (!valid_q[i]) alloc_oh[i] = 1'b1;
            if (valid_q[i] && expired_q[i]) begin
                exp_oh     = '0;
                exp_oh[i]  = 1'b1;
                exp_src    = src_q[i];
            end
        end
    end

    assign admit         = run_q & enable & (count_q < MAX_CNT) & ~dup;
    assign req_out_valid = req_in_valid & admit;
    assign req_in_ready  = req_out_ready & admit;
    assign req_out_data  = req_in_data;
    assign req_hs        = req_in_valid & req_out_ready & admit;

    always_comb begin
        synth_pkt                   = '0;
        synth_pkt[CHAN_LSB +: 3]    = 3'b111;
        synth_pkt[SRC_LSB +: 8]     = lock_src_q;
    end

    // Response FSM: real responses win; injection only starts on an idle input cycle.
    always_comb begin
        state_d       = state_q;
        lock_oh_d     = lock_oh_q;
        lock_src_d    = lock_src_q;
        rsp_out_valid = 1'b0;
        rsp_out_data  = rsp_in_data;
        rsp_in_ready  = 1'b0;
        rsp_hs        = 1'b0;
        free_oh       = '0;
        inj_done      = 1'b0;
        unique case (state_q)
            StFwd: begin
                if (run_q) begin
                    if (rsp_in_valid) begin
                        rsp_out_valid = 1'b1;
                        rsp_in_ready  = rsp_out_ready;
                        rsp_hs        = rsp_out_ready;
                        if (rsp_out_ready) free_oh = match_oh;
                    end else if (|exp_oh) begin
                        state_d    = StInj;
                        lock_oh_d  = exp_oh;
                        lock_src_d = exp_src;
                    end
                end
            end
            StInj: begin
                rsp_out_valid = 1'b1;
                rsp_out_data  = synth_pkt;
                if (rsp_out_ready) begin
                    free_oh  = lock_oh_q;
                    inj_done = 1'b1;
                    state_d  = StFwd;
                end
            end
            default: state_d = StFwd;
        endcase
    end

    // Tracker next state; a free overrides a same-edge expiry.
    always_comb begin
        valid_d   = valid_q;
        expired_d = expired_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            src_d[i] = src_q[i];
            age_d[i] = age_q[i];
            if (valid_q[i] && !expired_q[i]) begin
                if (age_q[i] == AGE_LAST) expired_d[i] = 1'b1;
                else                      age_d[i] = age_q[i] + AGE_W'(1);
            end
            if (free_oh[i]) begin
                valid_d[i]   = 1'b0;
                expired_d[i] = 1'b0;
                age_d[i]     = '0;
            end
            if (req_hs && alloc_oh[i]) begin
                valid_d[i]   = 1'b1;
                expired_d[i] = 1'b0;
                src_d[i]     = req_src;
                age_d[i]     = '0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (req_hs && !(|free_oh))      count_d = count_q + 4'd1;
        else if (!req_hs && (|free_oh)) count_d = count_q - 4'd1;

        unexp_cnt_d = unexp_cnt_q;
        if (rsp_hs && !(|match_oh) && unexp_cnt_q != 8'hFF) unexp_cnt_d = unexp_cnt_q + 8'd1;

        tmo_cnt_d = tmo_cnt_q;
        if (inj_done && tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;

        pulse_d = inj_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= '0;
            expired_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                src_q[i] <= '0;
                age_q[i] <= '0;
            end
            state_q     <= StFwd;
            lock_oh_q   <= '0;
            lock_src_q  <= '0;
            count_q     <= '0;
            tmo_cnt_q   <= '0;
            unexp_cnt_q <= '0;
            pulse_q     <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            expired_q   <= expired_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                src_q[i] <= src_d[i];
                age_q[i] <= age_d[i];
            end
            state_q     <= state_d;
            lock_oh_q   <= lock_oh_d;
            lock_src_q  <= lock_src_d;
            count_q     <= count_d;
            tmo_cnt_q   <= tmo_cnt_d;
            unexp_cnt_q <= unexp_cnt_d;
            pulse_q     <= pulse_d;
            run_q       <= 1'b1;
        end
    end

    assign outstanding_count = count_q;
    assign timeout_pulse     = pulse_q;
    assign timeout_count     = tmo_cnt_q;
    assign unexpected_count  = unexp_cnt_q;

endmodule

// File: doc/stl_txn_scheduler.md
Name: stl_txn_scheduler

Overview:
- Flow controller between the STL UART client's 128-bit request/response packet streams and the UART<->TileLink bridges.
- Caps in-flight TileLink requests and blocks reuse of an in-flight source ID.
- Times out requests whose response never returns from SCuM-V, and injects a synthetic error response so the host never hangs.
- Runs entirely in the sysclk domain; both bridges keep their own tl_clk crossings.

Parameters:
- MAX_OUTSTANDING, 4, tracker entries (1..8).
- TIMEOUT_CYCLES, 1000000, clk cycles from request handshake to expiry (>=2).
- SRC_LSB, 16, LSB of the 8-bit source field in the 128-bit packet (same position in requests and responses).
- CHAN_LSB, 0, LSB of the 3-bit chanId field in the packet.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = admit new requests
- req_in_valid  in  1  request packet from UART client
- req_in_ready  out  1  request accepted
- req_in_data  in  128  request packet
- req_out_valid  out  1  request to UART-to-TileLink bridge
- req_out_ready  in  1  bridge accepts request
- req_out_data  out  128  request packet (pass-through)
- rsp_in_valid  in  1  response from TileLink-to-UART bridge
- rsp_in_ready  out  1  response accepted
- rsp_in_data  in  128  response packet
- rsp_out_valid  out  1  response to UART client
- rsp_out_ready  in  1  client accepts response
- rsp_out_data  out  128  response packet
- outstanding_count  out  4  valid tracker entries
- timeout_pulse  out  1  one-cycle pulse when a synthetic response is accepted
- timeout_count  out  8  saturating count of timeouts
- unexpected_count  out  8  saturating count of untracked responses

Behaviour:
- Reset (async, reset_n=0): all tracker entries invalid; ages 0; response FSM in FWD; all counters 0; timeout_pulse 0; req_in_ready, req_out_valid, rsp_out_valid and rsp_in_ready all 0 while reset is held.
- Tracker entry: {valid, src[7:0], age, expired}. src = data[SRC_LSB+:8].

Request admission (combinational, zero latency):
- admit = enable & (outstanding_count < MAX_OUTSTANDING) & no valid entry with src equal to the request source.
- The duplicate check uses the registered table. A same-cycle free does not unblock the request; it stalls one cycle.
- req_out_valid = req_in_valid & admit.
- req_in_ready = req_out_ready & admit.
- req_out_data = req_in_data.
- On handshake: allocate the lowest-index free entry with age=0 and expired=0.
- Deasserting enable blocks new admits only; in-flight entries continue to age and retire.

Ageing:
- Each valid, non-expired entry increments age every cycle.
- When age reaches TIMEOUT_CYCLES-1, the entry sets expired on the next edge.

Response FSM (states FWD, INJ):
- FWD, rsp_in_valid=1: rsp_out mirrors rsp_in; rsp_in_ready = rsp_out_ready. Real responses have priority.
- FWD, rsp_in_valid=0, any expired entry: move to INJ, locking the lowest-index expired entry.
- INJ: rsp_out_valid=1 and rsp_out_data = synthetic packet (all zero, chanId field=3'b111, source field=locked src); rsp_in_ready=0.
  - INJ holds until rsp_out_ready.
  - On acceptance: free the entry, pulse timeout_pulse, increment timeout_count, return to FWD.

Real response handshake:
- CAM match on src frees the matching entry, including an expired entry not yet locked; that cancels its injection.
- No match: forward anyway and increment unexpected_count.
- A real response for an entry already locked in INJ is handled after INJ completes, so it counts as unexpected.

Counters and widths:
- outstanding_count: +1 on allocate, -1 on free. Alloc and free in the same cycle leave it unchanged.
- Age counter width = clog2(TIMEOUT_CYCLES).
- timeout_count and unexpected_count saturate at 255.
- Reset mid-transaction drops all tracking; later responses for the dropped entries count as unexpected.

Test Plan:
- MAX=4: send 5 requests with src 1..5, no responses -> first 4 pass with zero latency, 5th stalls (req_in_ready=0) with outstanding_count=4. Return response src=2 -> count 3; src=5 forwarded on the next cycle.
- Send src=7; while in flight, offer another src=7 -> stalled. Response src=7 returns -> count 0 and the second src=7 is admitted one cycle later.
- TIMEOUT_CYCLES=16: one request src=0x3A, no response -> rsp_out shows synthetic packet (chanId 3'b111, source 0x3A) within 18 cycles of the handshake; timeout_pulse=1 for one cycle; timeout_count=1; count 0.
- Expiry coincides with a real rsp_in_valid for another source -> real response forwarded first, synthetic injected next. Hold rsp_out_ready=0 for 5 cycles during INJ -> data stays stable and rsp_in_ready=0.
- Response src=0x99 with empty tracker -> forwarded unchanged; unexpected_count=1; count stays 0.
- 3 requests in flight, then reset_n pulsed low mid-stream -> all outputs and counters 0 immediately (async). After release, the old responses count unexpected_count=3.
